// File: rtl/phase_decode_pkg.sv
// Shared types and constants for the two-phase clock pattern decoder.
package phase_decode_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [1:0] PAT_P1  = 2'b10;
  localparam logic [1:0] PAT_GAP = 2'b00;
  localparam logic [1:0] PAT_P2  = 2'b01;
  localparam logic [1:0] PAT_OVL = 2'b11;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_SEQ     = 2'b01;
  localparam logic [1:0] ERR_OVERLAP = 2'b10;
  localparam logic [1:0] ERR_OS      = 2'b11;

  localparam int GOOD_W = 4;

  // Phase index 0=P1, 1=gap A, 2=P2, 3=gap B.
  function automatic logic [1:0] phase_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    phase_pattern = PAT_P1;
      2'd2:    phase_pattern = PAT_P2;
      default: phase_pattern = PAT_GAP;
    endcase
  endfunction

endpackage

// File: rtl/phase_decode_sat_counter.sv
// Up-counter with synchronous reset and clear that stops at MAX.
module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/phase_decode.sv
// Samples the generator's CLK1/CLK2/O_S, locks onto the 4-cycle phase
// pattern and turns it into master-clock phase strobes plus error reporting.
module phase_decode
  import phase_decode_pkg::*;
#(
  parameter int LOCK_PERIODS = 4,
  parameter int HUNT_TIMEOUT = 8,
  parameter int ERR_W        = 4,
  parameter bit CHECK_OS     = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK1,
  input  logic             CLK2,
  input  logic             O_S,
  output logic             PH1,
  output logic             PH2,
  output logic [1:0]       PHASE,
  output logic             LOCK,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int HUNT_W = $clog2(HUNT_TIMEOUT + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_c1;
  logic                r_c2;
  logic                r_os;
  logic                r_os_prev;
  logic [1:0]          r_phase;
  logic                r_lock;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic                r_ph1;
  logic                r_ph2;
  logic [HUNT_W-1:0]   r_hunt_cnt;
  logic [GOOD_W-1:0]   w_good_cnt;

  logic [1:0]          w_sample;
  logic [1:0]          w_exp;
  logic [HUNT_W-1:0]   w_hunt_inc;
  logic                w_os_toggled;
  logic                w_err;
  logic [1:0]          w_code;
  logic                w_match;
  logic                w_acq;
  logic                w_lock_next;

  assign w_sample     = {r_c1, r_c2};
  assign w_exp        = r_phase + 2'd1;
  assign w_hunt_inc   = r_hunt_cnt + HUNT_W'(1);
  assign w_os_toggled = r_os ^ r_os_prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A failing sample that is itself P1 re-acquires instead of hunting.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT: begin
        if (w_sample == PAT_P1) begin
          w_state_next = TRACK;
        end
      end
      TRACK: begin
        if (w_err) begin
          w_state_next = (w_sample == PAT_P1) ? TRACK : HUNT;
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  always_comb begin
    w_err   = 1'b0;
    w_code  = ERR_TIMEOUT;
    w_match = 1'b0;
    w_acq   = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_sample == PAT_OVL) begin
          w_err  = 1'b1;
          w_code = ERR_OVERLAP;
        end else if (w_sample == PAT_P1) begin
          w_acq = 1'b1;
        end else if (w_hunt_inc == HUNT_W'(HUNT_TIMEOUT)) begin
          w_err  = 1'b1;
          w_code = ERR_TIMEOUT;
        end
      end
      TRACK: begin
        if (w_sample == PAT_OVL) begin
          w_err  = 1'b1;
          w_code = ERR_OVERLAP;
        end else if (w_sample != phase_pattern(w_exp)) begin
          w_err  = 1'b1;
          w_code = ERR_SEQ;
        end else if (CHECK_OS && (w_os_toggled != ~w_exp[0])) begin
          w_err  = 1'b1;
          w_code = ERR_OS;
        end else begin
          w_match = 1'b1;
        end
        w_acq = w_err && (w_sample == PAT_P1);
      end
      default: ;
    endcase
  end

  assign w_lock_next = w_err ? 1'b0 :
                       (w_match && (w_exp == 2'd0) &&
                        (w_good_cnt >= GOOD_W'(LOCK_PERIODS - 1))) ? 1'b1 :
                       r_lock;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_c1       <= 1'b0;
      r_c2       <= 1'b0;
      r_os       <= 1'b0;
      r_os_prev  <= 1'b0;
      r_phase    <= 2'd0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_TIMEOUT;
      r_ph1      <= 1'b0;
      r_ph2      <= 1'b0;
      r_hunt_cnt <= '0;
    end else begin
      r_c1      <= CLK1;
      r_c2      <= CLK2;
      r_os      <= O_S;
      r_os_prev <= r_os;
      r_lock    <= w_lock_next;
      r_err     <= w_err;
      r_ph1     <= w_match && (w_exp == 2'd0) && w_lock_next;
      r_ph2     <= w_match && (w_exp == 2'd2) && w_lock_next;
      if (w_err) begin
        r_err_code <= w_code;
      end
      if (w_acq) begin
        r_phase <= 2'd0;
      end else if (w_match) begin
        r_phase <= w_exp;
      end
      if ((r_state == HUNT) && !w_acq && !w_err) begin
        r_hunt_cnt <= w_hunt_inc;
      end else begin
        r_hunt_cnt <= '0;
      end
    end
  end

  sat_counter #(
    .W   (GOOD_W),
    .MAX (GOOD_W'(LOCK_PERIODS))
  ) u_good_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_match && (w_exp == 2'd0)),
    .i_clr (w_err || w_acq),
    .o_cnt (w_good_cnt)
  );

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_err),
    .i_clr (1'b0),
    .o_cnt (ERR_CNT)
  );

  assign PH1      = r_ph1;
  assign PH2      = r_ph2;
  assign PHASE    = r_phase;
  assign LOCK     = r_lock;
  assign ERR      = r_err;
  assign ERR_CODE = r_err_code;

endmodule

// File: tb/tb_phase_decode.sv
// Directed bench for phase_decode: two instances (O_S checking on and off)
// driven by a modelled two-phase generator with injected faults.
module tb_phase_decode;

  logic       CLK  = 1'b0;
  logic       RST  = 1'b1;
  logic       CLK1 = 1'b0;
  logic       CLK2 = 1'b0;
  logic       O_S  = 1'b0;

  logic       ph1, ph2, lock, err;
  logic [1:0] phase, errCode;
  logic [3:0] errCnt;
  logic       ph1N, ph2N, lockN, errN;
  logic [1:0] phaseN, errCodeN;
  logic [3:0] errCntN;

  int   checkCount = 0;
  int   errorCount = 0;
  int   genIdx     = 0;
  logic osVal      = 1'b0;

  always #5 CLK = ~CLK;

  phase_decode #(
    .LOCK_PERIODS (4),
    .HUNT_TIMEOUT (8),
    .ERR_W        (4),
    .CHECK_OS     (1'b1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLK1     (CLK1),
    .CLK2     (CLK2),
    .O_S      (O_S),
    .PH1      (ph1),
    .PH2      (ph2),
    .PHASE    (phase),
    .LOCK     (lock),
    .ERR      (err),
    .ERR_CODE (errCode),
    .ERR_CNT  (errCnt)
  );

  phase_decode #(
    .LOCK_PERIODS (4),
    .HUNT_TIMEOUT (8),
    .ERR_W        (4),
    .CHECK_OS     (1'b0)
  ) dutNoOs (
    .CLK      (CLK),
    .RST      (RST),
    .CLK1     (CLK1),
    .CLK2     (CLK2),
    .O_S      (O_S),
    .PH1      (ph1N),
    .PH2      (ph2N),
    .PHASE    (phaseN),
    .LOCK     (lockN),
    .ERR      (errN),
    .ERR_CODE (errCodeN),
    .ERR_CNT  (errCntN)
  );

  // Inputs change right after a falling edge; outputs are read there too.
  task automatic applyStimulus(input logic c1, input logic c2, input logic os);
    CLK1 = c1;
    CLK2 = c2;
    O_S  = os;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One generator cycle with explicit CLK1/CLK2; O_S toggles on P1/P2 slots.
  task automatic genFault(input logic c1, input logic c2, input bit holdOs);
    if ((genIdx % 2 == 0) && !holdOs) osVal = ~osVal;
    applyStimulus(c1, c2, osVal);
    genIdx++;
  endtask

  task automatic genStep();
    case (genIdx % 4)
      0:       genFault(1'b1, 1'b0, 1'b0);
      2:       genFault(1'b0, 1'b1, 1'b0);
      default: genFault(1'b0, 1'b0, 1'b0);
    endcase
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ph1"},    {7'd0, ph1},     8'd0);
    checkOutput({tag, "_ph2"},    {7'd0, ph2},     8'd0);
    checkOutput({tag, "_lock"},   {7'd0, lock},    8'd0);
    checkOutput({tag, "_err"},    {7'd0, err},     8'd0);
    checkOutput({tag, "_phase"},  {6'd0, phase},   8'd0);
    checkOutput({tag, "_code"},   {6'd0, errCode}, 8'd0);
    checkOutput({tag, "_cnt"},    {4'd0, errCnt},  8'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("reset");
    RST = 1'b0;

    // Ideal stream: acquisition on P1 #1, lock on P1 #5 (call 17).
    repeat (17) genStep();
    checkOutput("prelock_lock", {7'd0, lock}, 8'd0);
    genStep();
    checkOutput("lock_rise", {7'd0, lock}, 8'd1);
    checkOutput("lock_ph1",  {7'd0, ph1},  8'd1);
    checkOutput("lock_ph2",  {7'd0, ph2},  8'd0);
    checkOutput("lock_phase", {6'd0, phase}, 8'd0);
    checkOutput("lock_err",  {7'd0, err},  8'd0);
    genStep();
    checkOutput("gapA_ph1", {7'd0, ph1}, 8'd0);
    checkOutput("gapA_ph2", {7'd0, ph2}, 8'd0);
    checkOutput("gapA_phase", {6'd0, phase}, 8'd1);
    genStep();
    checkOutput("p2_ph2",   {7'd0, ph2}, 8'd1);
    checkOutput("p2_ph1",   {7'd0, ph1}, 8'd0);
    checkOutput("p2_phase", {6'd0, phase}, 8'd2);
    genStep();
    checkOutput("gapB_ph2", {7'd0, ph2}, 8'd0);
    checkOutput("gapB_phase", {6'd0, phase}, 8'd3);
    genStep();
    checkOutput("p1b_ph1", {7'd0, ph1}, 8'd1);
    checkOutput("ideal_cnt", {4'd0, errCnt}, 8'd0);

    // Overlap in the P2 slot while locked.
    genFault(1'b1, 1'b1, 1'b0);
    genStep();
    checkOutput("ovl_err",  {7'd0, err},     8'd1);
    checkOutput("ovl_code", {6'd0, errCode}, 8'd2);
    checkOutput("ovl_lock", {7'd0, lock},    8'd0);
    checkOutput("ovl_cnt",  {4'd0, errCnt},  8'd1);
    checkOutput("ovl_ph2",  {7'd0, ph2},     8'd0);
    genStep();
    checkOutput("ovl_err_pulse", {7'd0, err}, 8'd0);
    checkOutput("ovl_code_hold", {6'd0, errCode}, 8'd2);
    genStep();
    checkOutput("reacq_phase", {6'd0, phase}, 8'd0);
    checkOutput("reacq_ph1",   {7'd0, ph1},   8'd0);
    repeat (15) genStep();
    checkOutput("relock_pre", {7'd0, lock}, 8'd0);
    genStep();
    checkOutput("relock_lock", {7'd0, lock}, 8'd1);
    checkOutput("relock_ph1",  {7'd0, ph1},  8'd1);

    // Dropped P2.
    genFault(1'b0, 1'b0, 1'b0);
    genStep();
    checkOutput("drop_err",  {7'd0, err},     8'd1);
    checkOutput("drop_code", {6'd0, errCode}, 8'd1);
    checkOutput("drop_lock", {7'd0, lock},    8'd0);
    checkOutput("drop_cnt",  {4'd0, errCnt},  8'd2);
    genStep();
    checkOutput("drop_hunt_err", {7'd0, err}, 8'd0);
    genStep();
    checkOutput("drop_reacq_phase", {6'd0, phase}, 8'd0);
    checkOutput("drop_reacq_err",   {7'd0, err},   8'd0);

    // O_S held on a P2 sample.
    genFault(1'b0, 1'b1, 1'b1);
    genStep();
    checkOutput("os_err",   {7'd0, err},      8'd1);
    checkOutput("os_code",  {6'd0, errCode},  8'd3);
    checkOutput("os_cnt",   {4'd0, errCnt},   8'd3);
    checkOutput("noos_err", {7'd0, errN},     8'd0);
    checkOutput("noos_cnt", {4'd0, errCntN},  8'd2);
    genStep();
    checkOutput("os_err_pulse", {7'd0, err},  8'd0);
    checkOutput("noos_err2",    {7'd0, errN}, 8'd0);
    checkOutput("noos_phase",   {6'd0, phaseN}, 8'd3);
    genStep();
    checkOutput("os_reacq_phase", {6'd0, phase}, 8'd0);

    // Inputs stuck low: sequence error, then a timeout every 8 cycles.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stuck_seq_err",  {7'd0, err},     8'd1);
    checkOutput("stuck_seq_code", {6'd0, errCode}, 8'd1);
    checkOutput("stuck_seq_cnt",  {4'd0, errCnt},  8'd4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stuck_code_hold", {6'd0, errCode}, 8'd1);
    checkOutput("stuck_err_low",   {7'd0, err},     8'd0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("to_before", {7'd0, err}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("to_err",  {7'd0, err},     8'd1);
    checkOutput("to_code", {6'd0, errCode}, 8'd0);
    checkOutput("to_cnt",  {4'd0, errCnt},  8'd5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("to_pulse", {7'd0, err}, 8'd0);
    repeat (78) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sat_err", {7'd0, err},    8'd1);
    checkOutput("sat_cnt", {4'd0, errCnt}, 8'd15);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sat_gap_err", {7'd0, err}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sat_hold_err",  {7'd0, err},     8'd1);
    checkOutput("sat_hold_cnt",  {4'd0, errCnt},  8'd15);
    checkOutput("sat_hold_code", {6'd0, errCode}, 8'd0);

    // Fresh reset, lock, then reset on the edge that evaluates an overlap.
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("reset2");
    RST    = 1'b0;
    genIdx = 0;
    osVal  = 1'b0;
    repeat (18) genStep();
    checkOutput("r2_lock", {7'd0, lock}, 8'd1);
    genFault(1'b1, 1'b1, 1'b0);
    RST = 1'b1;
    genStep();
    checkAllZero("rst_pending");
    RST = 1'b0;
    genStep();
    checkOutput("post_rst_err",  {7'd0, err},    8'd0);
    checkOutput("post_rst_cnt",  {4'd0, errCnt}, 8'd0);
    checkOutput("post_rst_lock", {7'd0, lock},   8'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
